// File: rtl/note_track_engine.sv
// Falling-note slot store: chart spawn on tick, per-tick advance, press judging and slot readout.
// Build option NOTE_SPEED_RAMP_EN adds streak[7:5] to the per-tick speed (saturating at 15).
module note_track_engine #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned SLOTS    = 40,
  parameter int unsigned POS_W    = 10,
  parameter int unsigned STRIKE_Y = 400,
  parameter int unsigned WINDOW   = 16,
  parameter int unsigned SLOT_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [3:0]         speed,
  input  logic               chart_valid,
  input  logic [LANES-1:0]   chart_lanes,
  output logic               chart_ready,
  input  logic [LANES-1:0]   lane_press,
  output logic [LANES-1:0]   hit_pulse,
  output logic               bad_press,
  output logic               miss_pulse,
  output logic [15:0]        score,
  output logic [7:0]         streak,
  output logic [15:0]        miss_count,
  output logic               stall,
  input  logic [SLOT_AW-1:0] rd_slot,
  output logic               rd_valid,
  output logic [LANES-1:0]   rd_lanes,
  output logic [POS_W-1:0]   rd_y
);

  localparam int unsigned HiY = STRIKE_Y + WINDOW;

  // Written as y + WINDOW >= STRIKE_Y so a window reaching below zero needs no signed maths.
  function automatic logic in_window(input logic [POS_W-1:0] y);
    return (32'(y) + WINDOW >= STRIKE_Y) && (32'(y) <= HiY);
  endfunction

  logic             valid_q [SLOTS];
  logic             valid_d [SLOTS];
  logic [LANES-1:0] mask_q  [SLOTS];
  logic [LANES-1:0] mask_d  [SLOTS];
  logic [POS_W-1:0] y_q     [SLOTS];
  logic [POS_W-1:0] y_d     [SLOTS];

  logic [LANES-1:0] hit_q, hit_d;
  logic             bad_q, bad_d;
  logic             miss_q, miss_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       streak_q, streak_d;
  logic [15:0]      mc_q, mc_d;
  logic             stall_q, stall_d;
  logic             rd_valid_q, rd_valid_d;
  logic [LANES-1:0] rd_lanes_q, rd_lanes_d;
  logic [POS_W-1:0] rd_y_q, rd_y_d;

  logic             ready_c;
  logic             spawn_done;
  logic             pr_found;
  logic [POS_W-1:0] pr_best_y;
  logic [SLOT_AW-1:0] pr_idx;
  logic [POS_W:0]   adv;
  logic [7:0]       hit_cnt;
  logic [15:0]      miss_n;
  logic [16:0]      score_sum;
  logic [8:0]       streak_sum;
  logic [16:0]      mc_sum;
  logic [3:0]       eff_speed;

`ifdef NOTE_SPEED_RAMP_EN
  logic [4:0] ramp_sum;
  assign ramp_sum  = {1'b0, speed} + {2'b00, streak_q[7:5]};
  assign eff_speed = ramp_sum[4] ? 4'hF : ramp_sum[3:0];
`else
  assign eff_speed = speed;
`endif

  always_comb begin
    valid_d    = valid_q;
    mask_d     = mask_q;
    y_d        = y_q;
    hit_d      = '0;
    bad_d      = 1'b0;
    hit_cnt    = '0;
    miss_n     = '0;
    spawn_done = 1'b0;
    pr_found   = 1'b0;
    pr_best_y  = '0;
    pr_idx     = '0;
    adv        = '0;

    // Judge presses on pre-tick state; each lane picks the lowest note in the window.
    for (int k = 0; k < LANES; k++) begin
      if (lane_press[k]) begin
        pr_found  = 1'b0;
        pr_best_y = '0;
        pr_idx    = '0;
        for (int i = 0; i < SLOTS; i++) begin
          if (valid_q[i] && mask_q[i][k] && in_window(y_q[i]) &&
              (!pr_found || y_q[i] > pr_best_y)) begin
            pr_found  = 1'b1;
            pr_best_y = y_q[i];
            pr_idx    = SLOT_AW'(i);
          end
        end
        if (pr_found) begin
          hit_d[k] = 1'b1;
          hit_cnt  = hit_cnt + 8'd1;
          for (int i = 0; i < SLOTS; i++) begin
            if (pr_idx == SLOT_AW'(i)) mask_d[i][k] = 1'b0;
          end
        end else begin
          bad_d = 1'b1;
        end
      end
    end

    for (int i = 0; i < SLOTS; i++) begin
      if (valid_d[i] && mask_d[i] == '0) begin
        valid_d[i] = 1'b0;
        y_d[i]     = '0;
      end
    end

    if (tick) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (valid_d[i]) begin
          adv    = {1'b0, y_q[i]} + {{(POS_W-3){1'b0}}, eff_speed};
          y_d[i] = adv[POS_W] ? '1 : adv[POS_W-1:0];
          if (32'(y_d[i]) > HiY) begin
            if (mask_d[i] != '0) miss_n = miss_n + 16'd1;
            valid_d[i] = 1'b0;
            mask_d[i]  = '0;
            y_d[i]     = '0;
          end
        end
      end
    end

    // Spawn goes in after this cycle's frees, so a just-retired slot is reusable at once.
    if (tick && chart_valid && chart_lanes != '0) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (!spawn_done && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          mask_d[i]  = chart_lanes;
          y_d[i]     = '0;
          spawn_done = 1'b1;
        end
      end
    end

    ready_c = tick && chart_valid && (chart_lanes == '0 || spawn_done);
    stall_d = stall_q | (tick && chart_valid && chart_lanes != '0 && !spawn_done);
    miss_d  = (miss_n != '0);

    score_sum  = {1'b0, score_q} + 17'(hit_cnt);
    score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    streak_sum = {1'b0, streak_q} + 9'(hit_cnt);
    streak_d   = (bad_d || miss_d) ? 8'h00 : (streak_sum[8] ? 8'hFF : streak_sum[7:0]);
    mc_sum     = {1'b0, mc_q} + {1'b0, miss_n};
    mc_d       = mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
  end

  always_comb begin
    rd_valid_d = 1'b0;
    rd_lanes_d = '0;
    rd_y_d     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (rd_slot == SLOT_AW'(i)) begin
        rd_valid_d = valid_q[i];
        rd_lanes_d = mask_q[i];
        rd_y_d     = y_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        valid_q[i] <= 1'b0;
        mask_q[i]  <= '0;
        y_q[i]     <= '0;
      end
      hit_q      <= '0;
      bad_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      streak_q   <= '0;
      mc_q       <= '0;
      stall_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_lanes_q <= '0;
      rd_y_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      mask_q     <= mask_d;
      y_q        <= y_d;
      hit_q      <= hit_d;
      bad_q      <= bad_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      streak_q   <= streak_d;
      mc_q       <= mc_d;
      stall_q    <= stall_d;
      rd_valid_q <= rd_valid_d;
      rd_lanes_q <= rd_lanes_d;
      rd_y_q     <= rd_y_d;
    end
  end

  assign chart_ready = ready_c && !reset;
  assign hit_pulse   = hit_q;
  assign bad_press   = bad_q;
  assign miss_pulse  = miss_q;
  assign score       = score_q;
  assign streak      = streak_q;
  assign miss_count  = mc_q;
  assign stall       = stall_q;
  assign rd_valid    = rd_valid_q;
  assign rd_lanes    = rd_lanes_q;
  assign rd_y        = rd_y_q;

endmodule

// File: tb/tb_note_track_engine.sv
// Bench for note_track_engine: directed scenarios plus randomized traffic against a slot-list model.
module tb_note_track_engine;
  localparam int SLOTS = 40;
  localparam int STRIKE_Y = 400;
  localparam int WINDOW = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       chart_valid = 1'b0;
  logic [3:0] chart_lanes = 4'd0;
  logic       chart_ready;
  logic [3:0] lane_press = 4'd0;
  logic [3:0] hit_pulse;
  logic       bad_press, miss_pulse, stall;
  logic [15:0] score, miss_count;
  logic [7:0] streak;
  logic [5:0] rd_slot = 6'd0;
  logic       rd_valid;
  logic [3:0] rd_lanes;
  logic [9:0] rd_y;

  always #5 clk = ~clk;

  note_track_engine u_dut (
    .clk(clk), .reset(reset), .tick(tick), .speed(speed),
    .chart_valid(chart_valid), .chart_lanes(chart_lanes), .chart_ready(chart_ready),
    .lane_press(lane_press), .hit_pulse(hit_pulse), .bad_press(bad_press),
    .miss_pulse(miss_pulse), .score(score), .streak(streak), .miss_count(miss_count),
    .stall(stall), .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_lanes(rd_lanes), .rd_y(rd_y)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain list of notes with integer positions.
  bit         m_valid [SLOTS];
  logic [3:0] m_mask  [SLOTS];
  int         m_y     [SLOTS];
  int         m_score, m_streak, m_mc;
  bit         m_stall;
  bit         e_ready, e_bad, e_miss, e_rdv, e_rd_all;
  logic [3:0] e_hit, e_rdl;
  int         e_rdy;
  logic       o_ready;

  task automatic model_step(input logic [3:0] pr, input bit tk, input int spd, input bit cv,
                            input logic [3:0] cl, input bit rst, input int rs);
    int hits, nmiss, eff, best;
    bit bad, placed;
    if (rs >= SLOTS) begin
      e_rdv = 0; e_rdl = 0; e_rdy = 0; e_rd_all = 1;
    end else begin
      e_rdv = m_valid[rs]; e_rdl = m_mask[rs]; e_rdy = m_y[rs]; e_rd_all = m_valid[rs];
    end
    e_hit = 0; e_bad = 0; e_miss = 0; e_ready = 0;
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin m_valid[i] = 0; m_mask[i] = 0; m_y[i] = 0; end
      m_score = 0; m_streak = 0; m_mc = 0; m_stall = 0;
      e_rdv = 0; e_rdl = 0; e_rdy = 0; e_rd_all = 1;
      return;
    end
    hits = 0; bad = 0; nmiss = 0; placed = 0;
    for (int k = 0; k < 4; k++) begin
      if (pr[k]) begin
        best = -1;
        for (int i = 0; i < SLOTS; i++)
          if (m_valid[i] && m_mask[i][k] && m_y[i] >= STRIKE_Y - WINDOW &&
              m_y[i] <= STRIKE_Y + WINDOW && (best < 0 || m_y[i] > m_y[best]))
            best = i;
        if (best >= 0) begin
          m_mask[best][k] = 1'b0;
          if (m_mask[best] == 4'd0) m_valid[best] = 0;
          e_hit[k] = 1'b1;
          hits++;
        end else bad = 1;
      end
    end
    eff = spd;
`ifdef NOTE_SPEED_RAMP_EN
    eff = spd + m_streak / 32;
    if (eff > 15) eff = 15;
`endif
    if (tk) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (m_valid[i]) begin
          m_y[i] = m_y[i] + eff;
          if (m_y[i] > 1023) m_y[i] = 1023;
          if (m_y[i] > STRIKE_Y + WINDOW) begin m_valid[i] = 0; nmiss++; end
        end
      end
      if (cv) begin
        if (cl == 4'd0) e_ready = 1;
        else begin
          for (int i = 0; i < SLOTS; i++)
            if (!placed && !m_valid[i]) begin
              m_valid[i] = 1; m_mask[i] = cl; m_y[i] = 0; placed = 1;
            end
          if (placed) e_ready = 1; else m_stall = 1;
        end
      end
    end
    m_score = (m_score + hits > 65535) ? 65535 : m_score + hits;
    if (bad || nmiss > 0) m_streak = 0;
    else m_streak = (m_streak + hits > 255) ? 255 : m_streak + hits;
    m_mc = (m_mc + nmiss > 65535) ? 65535 : m_mc + nmiss;
    e_bad = bad;
    e_miss = (nmiss > 0);
  endtask

  task automatic cycle(input logic [3:0] pr, input bit tk, input int spd, input bit cv,
                       input logic [3:0] cl, input bit rst = 1'b0);
    lane_press = pr; tick = tk; speed = 4'(spd); chart_valid = cv; chart_lanes = cl; reset = rst;
    #1;
    o_ready = chart_ready;
    model_step(pr, tk, spd, cv, cl, rst, int'(rd_slot));
    @(posedge clk);
    #1;
    lane_press = 0; tick = 0; chart_valid = 0; chart_lanes = 0; reset = 0;
  endtask

  task automatic read_slot(input int idx);
    rd_slot = 6'(idx);
    cycle(4'd0, 0, 0, 0, 4'd0);
  endtask

  task automatic test_reset();
    cycle(4'd0, 1, 4, 1, 4'b0001, 1);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", o_ready); end
    checks++; if (score !== 16'd0 || streak !== 8'd0 || miss_count !== 16'd0)
      begin errors++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", score, streak, miss_count); end
    checks++; if (stall !== 1'b0 || hit_pulse !== 4'd0 || bad_press !== 1'b0 || miss_pulse !== 1'b0)
      begin errors++; $display("FAIL rst_flags: got %b %b %b %b want 0", stall, hit_pulse, bad_press, miss_pulse); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_slot0: got %b want 0", rd_valid); end
  endtask

  task automatic test_hit();
    cycle(4'd0, 0, 0, 0, 4'd0, 1);
    cycle(4'd0, 1, 4, 1, 4'b0001);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hit_ready: got %b want 1", o_ready); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b1 || rd_y !== 10'd0)
      begin errors++; $display("FAIL hit_spawn: got v=%b y=%0d want v=1 y=0", rd_valid, rd_y); end
    repeat (96) cycle(4'd0, 1, 4, 0, 4'd0);
    read_slot(0);
    checks++; if (rd_y !== 10'd384) begin errors++; $display("FAIL hit_y384: got %0d want 384", rd_y); end
    cycle(4'b0001, 0, 4, 0, 4'd0);
    checks++; if (hit_pulse !== 4'b0001 || score !== 16'd1 || streak !== 8'd1)
      begin errors++; $display("FAIL hit_judge: got %b/%0d/%0d want 0001/1/1", hit_pulse, score, streak); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL hit_freed: got %b want 0", rd_valid); end
  endtask

  task automatic test_miss();
    cycle(4'd0, 1, 4, 1, 4'b0001);
    repeat (104) cycle(4'd0, 1, 4, 0, 4'd0);
    read_slot(0);
    checks++; if (rd_valid !== 1'b1 || rd_y !== 10'd416)
      begin errors++; $display("FAIL miss_416: got v=%b y=%0d want v=1 y=416", rd_valid, rd_y); end
    cycle(4'd0, 1, 4, 0, 4'd0);
    checks++; if (miss_pulse !== 1'b1 || miss_count !== 16'd1 || streak !== 8'd0)
      begin errors++; $display("FAIL miss_retire: got %b/%0d/%0d want 1/1/0", miss_pulse, miss_count, streak); end
    read_slot(0);
    checks++; if (miss_pulse !== 1'b0 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL miss_once: got pulse=%b v=%b want 0 0", miss_pulse, rd_valid); end
  endtask

  task automatic test_chord();
    cycle(4'd0, 0, 0, 0, 4'd0, 1);
    cycle(4'd0, 1, 4, 1, 4'b0101);
    repeat (100) cycle(4'd0, 1, 4, 0, 4'd0);
    cycle(4'b0001, 0, 0, 0, 4'd0);
    checks++; if (hit_pulse !== 4'b0001) begin errors++; $display("FAIL chord_l0: got %b want 0001", hit_pulse); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b1 || rd_lanes !== 4'b0100 || rd_y !== 10'd400)
      begin errors++; $display("FAIL chord_rem: got v=%b l=%b y=%0d want 1 0100 400", rd_valid, rd_lanes, rd_y); end
    cycle(4'b0100, 0, 0, 0, 4'd0);
    checks++; if (hit_pulse !== 4'b0100 || score !== 16'd2 || streak !== 8'd2)
      begin errors++; $display("FAIL chord_l2: got %b/%0d/%0d want 0100/2/2", hit_pulse, score, streak); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL chord_freed: got %b want 0", rd_valid); end
    cycle(4'b0010, 0, 0, 0, 4'd0);
    checks++; if (bad_press !== 1'b1 || streak !== 8'd0 || hit_pulse !== 4'd0)
      begin errors++; $display("FAIL chord_bad: got %b/%0d/%b want 1/0/0000", bad_press, streak, hit_pulse); end
  endtask

  task automatic test_full_stall();
    cycle(4'd0, 0, 0, 0, 4'd0, 1);
    for (int n = 0; n < SLOTS; n++) begin
      cycle(4'd0, 1, 0, 1, 4'b0001);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", n, o_ready); end
    end
    cycle(4'd0, 1, 0, 1, 4'b0001);
    checks++; if (o_ready !== 1'b0 || stall !== 1'b1)
      begin errors++; $display("FAIL full_stall: got ready=%b stall=%b want 0 1", o_ready, stall); end
    repeat (40) cycle(4'd0, 1, 10, 0, 4'd0);
    cycle(4'b0001, 0, 0, 0, 4'd0);
    checks++; if (hit_pulse !== 4'b0001) begin errors++; $display("FAIL full_hit: got %b want 0001", hit_pulse); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL full_free0: got %b want 0", rd_valid); end
    cycle(4'd0, 1, 0, 1, 4'b0010);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL full_refill: got %b want 1", o_ready); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b1 || rd_lanes !== 4'b0010 || rd_y !== 10'd0 || stall !== 1'b1)
      begin errors++; $display("FAIL full_slot0: got v=%b l=%b y=%0d s=%b want 1 0010 0 1", rd_valid, rd_lanes, rd_y, stall); end
  endtask

  task automatic test_rest_and_reset();
    cycle(4'd0, 1, 0, 1, 4'b0000);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rest_full: got %b want 1", o_ready); end
    cycle(4'd0, 1, 0, 1, 4'b0001, 1);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", o_ready); end
    checks++; if (score !== 16'd0 || stall !== 1'b0 || streak !== 8'd0)
      begin errors++; $display("FAIL midrst_state: got %0d/%b/%0d want 0/0/0", score, stall, streak); end
    read_slot(39);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_slot39: got %b want 0", rd_valid); end
    cycle(4'd0, 1, 0, 1, 4'b0000);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rest_free: got %b want 1", o_ready); end
    read_slot(0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rest_noslot: got %b want 0", rd_valid); end
  endtask

  task automatic test_speed();
    int want;
    cycle(4'd0, 0, 0, 0, 4'd0, 1);
    repeat (8) cycle(4'd0, 1, 0, 1, 4'b1111);
    repeat (40) cycle(4'd0, 1, 10, 0, 4'd0);
    repeat (8) cycle(4'b1111, 0, 0, 0, 4'd0);
    checks++; if (streak !== 8'd32 || score !== 16'd32)
      begin errors++; $display("FAIL spd_streak: got %0d/%0d want 32/32", streak, score); end
    cycle(4'd0, 1, 4, 1, 4'b0001);
    cycle(4'd0, 1, 4, 0, 4'd0);
    read_slot(0);
`ifdef NOTE_SPEED_RAMP_EN
    want = 5;
`else
    want = 4;
`endif
    checks++; if (rd_valid !== 1'b1 || int'(rd_y) != want)
      begin errors++; $display("FAIL spd_step: got v=%b y=%0d want 1 %0d", rd_valid, rd_y, want); end
  endtask

  task automatic test_random();
    logic [3:0] pr;
    cycle(4'd0, 0, 0, 0, 4'd0, 1);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) pr[k] = ($urandom_range(0, 3) == 0);
      rd_slot = 6'($urandom_range(0, 47));
      cycle(pr, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 599) == 0));
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, o_ready, e_ready); end
      checks++; if (hit_pulse !== e_hit) begin errors++; $display("FAIL rnd_hit c%0d: got %b want %b", c, hit_pulse, e_hit); end
      checks++; if (bad_press !== e_bad || miss_pulse !== e_miss)
        begin errors++; $display("FAIL rnd_badmiss c%0d: got %b %b want %b %b", c, bad_press, miss_pulse, e_bad, e_miss); end
      checks++; if (score !== 16'(m_score) || streak !== 8'(m_streak))
        begin errors++; $display("FAIL rnd_score c%0d: got %0d/%0d want %0d/%0d", c, score, streak, m_score, m_streak); end
      checks++; if (miss_count !== 16'(m_mc) || stall !== m_stall)
        begin errors++; $display("FAIL rnd_mc c%0d: got %0d/%b want %0d/%b", c, miss_count, stall, m_mc, m_stall); end
      checks++; if (rd_valid !== e_rdv || (e_rd_all && (rd_lanes !== e_rdl || int'(rd_y) != e_rdy)))
        begin errors++; $display("FAIL rnd_rd c%0d: got %b %b %0d want %b %b %0d", c, rd_valid, rd_lanes, rd_y, e_rdv, e_rdl, e_rdy); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_hit();
    test_miss();
    test_chord();
    test_full_stall();
    test_rest_and_reset();
    test_speed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_track_engine.md
Name: note_track_engine

Overview:
Parametrised successor to the fixed 40-entry note position arrays. Holds up to SLOTS falling notes across LANES lanes. It spawns notes from a chart stream through a valid/ready handshake, advances every note by a programmable speed on each frame tick, and judges lane presses against a strike window. It reports hits, misses, score and streak, and exposes a registered slot readout port for the VGA renderer.

Parameters:
LANES, 4, number of lanes (button/colour channels)
SLOTS, 40, note slot count
POS_W, 10, width of vertical position, unsigned
STRIKE_Y, 400, strike line position
WINDOW, 16, hit tolerance; hit when STRIKE_Y-WINDOW <= y <= STRIKE_Y+WINDOW
SLOT_AW, 6, slot index width, >= clog2(SLOTS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tick  in  1  frame-advance strobe, one cycle
speed  in  4  pixels added per tick
chart_valid  in  1  chart entry available
chart_lanes  in  LANES  lane mask of entry; 0 = rest
chart_ready  out  1  entry consumed this cycle
lane_press  in  LANES  press strobes, one cycle per press
hit_pulse  out  LANES  registered, per-lane hit
bad_press  out  1  registered, press with no note in window
miss_pulse  out  1  registered, at least one note retired unplayed
score  out  16  hit count, saturating
streak  out  8  consecutive hits, saturating
miss_count  out  16  retired unplayed slots, saturating
stall  out  1  sticky: entry pending at tick and no free slot
rd_slot  in  SLOT_AW  readout index
rd_valid  out  1  slot occupied (1-cycle latency)
rd_lanes  out  LANES  remaining lane mask (1-cycle latency)
rd_y  out  POS_W  slot position (1-cycle latency)

Behaviour:
- Reset (synchronous, clk edge with reset=1) clears all slots and all outputs to 0; chart_ready=0. Reset in mid-game discards all notes and any pending entry handshake. Reset has priority over all other inputs.
- Slot state: valid, mask[LANES], y[POS_W].
- Tick cycle, applied in order:
  (a) Presses judged against pre-tick positions.
  (b) Every valid slot that existed before the tick gets y += speed, saturating at all-ones.
  (c) Any slot with y > STRIKE_Y+WINDOW is freed. If its mask is nonzero, it counts as a miss: miss_count += number of such slots, miss_pulse=1, streak=0.
  (d) Spawn. If chart_valid=1, chart_ready=1 for this cycle only when:
      - chart_lanes==0 (rest, no slot taken), or
      - a free slot exists, in which case the lowest-index free slot (after freeing in (c)) gets valid=1, mask=chart_lanes, y=0.
    The new note is not advanced on its spawn tick.
  (e) If chart_valid=1 and no slot is free: chart_ready=0, the entry is held, stall is set. stall clears only on reset.
- chart_ready is never asserted without tick.
- Press judging, any cycle, for each lane k with lane_press[k]=1:
  - Candidate slots: valid, mask[k]=1, y inside the window. Choose the largest y; break ties by lowest index.
  - Clear mask[k]. If the mask becomes 0, free the slot.
  - Set hit_pulse[k], score += 1, streak += 1. Both saturate; score at 16'hFFFF, streak at 8'hFF.
  - Lanes are independent. Multiple simultaneous hits add popcount to score and streak.
  - A pressed lane with no candidate sets bad_press and streak=0. If hits and bad presses occur in the same cycle, the streak zeroes after the hits are added.
- Result outputs (hit_pulse, bad_press, miss_pulse) appear the cycle after the cause and are high for exactly one cycle.
- Readout returns state as of the previous edge. A read of a slot being updated in that same cycle returns the pre-update value.
- rd_slot >= SLOTS returns all zeros.

Optional Feature:
Macro: NOTE_SPEED_RAMP_EN.
- Defined: effective speed = speed + streak[7:5], saturating at 15, so speed rises every 32 consecutive hits. The effective speed is sampled at the tick cycle.
- Not defined: effective speed = speed exactly; streak has no effect on motion.

Test Plan:
1. Reset, then speed=4 and one entry 4'b0001 at tick 1. Expect chart_ready=1 on that tick and rd_y=0 for slot 0. After 96 more ticks rd_y=384. Press lane 0 → hit_pulse=4'b0001 next cycle, score=1, streak=1, slot 0 freed.
2. Same note, no press. After 104 ticks y=416 and the slot stays valid. At tick 105 y=420 → slot freed, miss_pulse=1 once, miss_count=1, streak=0.
3. Chord 4'b0101 at y=400. Press lane 0 → mask becomes 4'b0100, slot still valid. Next cycle press lane 2 → slot freed, score=2. Pressing lane 1 → bad_press=1, streak=0.
4. Fill all 40 slots with speed=0, then offer a 41st entry. Expect chart_ready=0 and stall=1, entry held. Press-clear one slot at y=0 (set STRIKE_Y window to cover 0 via parameter override). Next tick spawns into that index.
5. chart_lanes=0 while slots are free: consumed on tick, no slot allocated. Reset asserted mid-stream: all rd_valid=0, score=0, stall=0 next cycle.
6. With NOTE_SPEED_RAMP_EN, speed=4, streak=32 → note advances 5 per tick. Without the macro → 4 per tick.
